// File: rtl/cordic_iter.sv
// Iterative CORDIC micro-rotation engine: one shift-add rotation per cycle, vectoring or rotation mode.
// Results are raw (gain-unscaled); a single-cycle out_valid strobes them, in_ready gates the next vector.
module cordic_iter #(
   parameter int DATA_WIDTH = 20,
   parameter int FRAC       = 16,
   parameter int ITER       = 12
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         mode,
   input  logic                         neg_in,
   input  logic [ITER-1:0]              dir_in,
   input  logic signed [DATA_WIDTH-1:0] x_in,
   input  logic signed [DATA_WIDTH-1:0] y_in,
   output logic                         out_valid,
   output logic signed [DATA_WIDTH-1:0] x_out,
   output logic signed [DATA_WIDTH-1:0] y_out,
   output logic [ITER-1:0]              dir_out,
   output logic                         neg_out
);

   localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

   if (ITER < 1 || ITER > DATA_WIDTH - 1 || FRAC < 0 || FRAC >= DATA_WIDTH) begin : g_param_check
      $error("cordic_iter: illegal DATA_WIDTH/FRAC/ITER combination");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                       state;
   logic [CNT_W-1:0]             cnt;
   logic                         mode_r;
   logic                         neg;
   logic [ITER-1:0]              dir;
   logic signed [DATA_WIDTH-1:0] x;
   logic signed [DATA_WIDTH-1:0] y;

   logic                         load_neg;
   logic                         d;
   logic signed [DATA_WIDTH-1:0] x_sh;
   logic signed [DATA_WIDTH-1:0] y_sh;
   logic signed [DATA_WIDTH-1:0] x_nxt;
   logic signed [DATA_WIDTH-1:0] y_nxt;

   always_comb begin
      // vectoring folds the left half-plane onto the right with a 180 degree pre-rotation
      load_neg = mode ? neg_in : x_in[DATA_WIDTH-1];
      x_sh     = x >>> cnt;
      y_sh     = y >>> cnt;
      d        = mode_r ? dir[cnt] : ~y[DATA_WIDTH-1];
      if (d) begin
         x_nxt = x + y_sh;
         y_nxt = y - x_sh;
      end else begin
         x_nxt = x - y_sh;
         y_nxt = y + x_sh;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         cnt       <= '0;
         mode_r    <= 1'b0;
         neg       <= 1'b0;
         dir       <= '0;
         x         <= '0;
         y         <= '0;
      end else begin
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  in_ready <= 1'b0;
                  state    <= RUN;
                  mode_r   <= mode;
                  dir      <= dir_in;
                  neg      <= load_neg;
                  cnt      <= '0;
                  x        <= load_neg ? -x_in : x_in;
                  y        <= load_neg ? -y_in : y_in;
               end
            end
            RUN: begin
               x        <= x_nxt;
               y        <= y_nxt;
               dir[cnt] <= d;
               cnt      <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(ITER - 1)) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
               end
            end
            DONE: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign x_out   = x;
   assign y_out   = y;
   assign dir_out = dir;
   assign neg_out = neg;

endmodule
